// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops N_BITS words and sends them LSB byte first as UART frames.
// Optional even parity bit (8E1) when FIFO_UART_TX_PARITY_EN is defined; default build is 8N1.
module fifo_uart_tx #(
   parameter int unsigned N_BITS       = 64,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [N_BITS-1:0] fifo_data,
   output logic              fifo_pop,
   output logic              tx,
   output logic              busy,
   output logic              word_done
);

   localparam int unsigned N_BYTES = N_BITS / 8;
   localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BYTE_W  = $clog2(N_BYTES) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

   if (N_BITS == 0 || (N_BITS % 8) != 0) begin : g_bad_n_bits
      $error("fifo_uart_tx: N_BITS must be a non-zero multiple of 8");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
   end

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StPop, StLoad, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [2:0] {StIdle, StPop, StLoad, StStart, StData, StStop} state_e;
`endif

   state_e              r_state, w_state_d;
   logic [BAUD_W-1:0]   r_baud, w_baud_d;
   logic [2:0]          r_bit_idx, w_bit_idx_d;
   logic [BYTE_W-1:0]   r_byte_idx, w_byte_idx_d;
   logic [N_BITS-1:0]   r_shift, w_shift_d;
   logic                r_tx, w_tx_d;
   logic                r_fifo_pop, w_fifo_pop_d;
   logic                r_busy;
   logic                r_word_done, w_word_done_d;
   logic                w_baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                r_par, w_par_d;
`endif

   assign w_baud_end = (r_baud == BAUD_LAST);

   always_comb begin
      w_state_d     = r_state;
      w_bit_idx_d   = r_bit_idx;
      w_byte_idx_d  = r_byte_idx;
      w_shift_d     = r_shift;
      w_fifo_pop_d  = 1'b0;
      w_word_done_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      w_par_d       = r_par;
`endif
      unique case (r_state)
         StIdle: begin
            // Pop pulse is raised here and the FSM leaves IDLE on the cycle it is visible.
            if (r_fifo_pop) begin
               w_state_d = StPop;
            end else if (tx_en && !fifo_empty) begin
               w_fifo_pop_d = 1'b1;
            end
         end
         StPop: begin
            w_state_d    = StLoad;
            w_shift_d    = fifo_data;
            w_byte_idx_d = '0;
         end
         StLoad: w_state_d = StStart;
         StStart: begin
            if (w_baud_end) begin
               w_state_d   = StData;
               w_bit_idx_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
               w_par_d     = 1'b0;
`endif
            end
         end
         StData: begin
            if (w_baud_end) begin
               w_shift_d = r_shift >> 1;
`ifdef FIFO_UART_TX_PARITY_EN
               w_par_d   = r_par ^ r_shift[0];
`endif
               if (r_bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  w_state_d = StParity;
`else
                  w_state_d = StStop;
`endif
               end else begin
                  w_bit_idx_d = r_bit_idx + 3'd1;
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         StParity: if (w_baud_end) w_state_d = StStop;
`endif
         StStop: begin
            if (w_baud_end) begin
               if (r_byte_idx == BYTE_LAST) begin
                  w_state_d     = StIdle;
                  w_word_done_d = 1'b1;
               end else begin
                  w_byte_idx_d = r_byte_idx + BYTE_W'(1);
                  w_state_d    = StStart;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_state_d != r_state || w_baud_end) begin
         w_baud_d = '0;
      end else begin
         w_baud_d = r_baud + BAUD_W'(1);
      end

      // Line level is decoded from the next state so tx is a clean register output.
      case (w_state_d)
         StStart:  w_tx_d = 1'b0;
         StData:   w_tx_d = w_shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         StParity: w_tx_d = w_par_d;
`endif
         default:  w_tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_baud      <= '0;
         r_bit_idx   <= '0;
         r_byte_idx  <= '0;
         r_shift     <= '0;
         r_tx        <= 1'b1;
         r_fifo_pop  <= 1'b0;
         r_busy      <= 1'b0;
         r_word_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         r_par       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_d;
         r_baud      <= w_baud_d;
         r_bit_idx   <= w_bit_idx_d;
         r_byte_idx  <= w_byte_idx_d;
         r_shift     <= w_shift_d;
         r_tx        <= w_tx_d;
         r_fifo_pop  <= w_fifo_pop_d;
         r_busy      <= (w_state_d != StIdle);
         r_word_done <= w_word_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
         r_par       <= w_par_d;
`endif
      end
   end

   assign fifo_pop  = r_fifo_pop;
   assign tx        = r_tx;
   assign busy      = r_busy;
   assign word_done = r_word_done;

endmodule
